// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main entry plus one skid entry, FIFO order, flush inserts a bubble.
// Latency: one cycle from accept to out_valid.
// Backpressure: absorbs two words; in_ready drops once the skid entry fills.
module pipe_stage_skid #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 133
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic              main_vld;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic deliver;

    // Occupancy doubles as the state encoding; skid is only ever valid behind a valid main.
    assign count     = {1'b0, main_vld} + {1'b0, skid_vld};
    assign in_ready  = ~skid_vld;
    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_ctrl : '0;
    assign out_data  = main_data;

    assign accept  = in_valid & in_ready;
    assign deliver = main_vld & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_vld  <= 1'b0;
            main_ctrl <= '0;
            skid_vld  <= 1'b0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_vld  <= 1'b0;
            main_ctrl <= '0;
            skid_vld  <= 1'b0;
            skid_ctrl <= '0;
        end else begin
            case (count)
                EMPTY: begin
                    if (accept) begin
                        main_vld  <= 1'b1;
                        main_ctrl <= in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        skid_vld  <= 1'b1;
                        skid_ctrl <= in_ctrl;
                    end else if (deliver) begin
                        main_vld  <= 1'b0;
                        main_ctrl <= '0;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_ctrl <= skid_ctrl;
                        skid_vld  <= 1'b0;
                        skid_ctrl <= '0;
                    end
                end
                default: begin
                    main_vld  <= 1'b0;
                    main_ctrl <= '0;
                    skid_vld  <= 1'b0;
                    skid_ctrl <= '0;
                end
            endcase
        end
    end

    // Payload registers keep their contents across a flush; only the valid/ctrl side is bubbled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (!flush) begin
            case (count)
                EMPTY: begin
                    if (accept) main_data <= in_data;
                end
                ONE: begin
                    if (accept && deliver) main_data <= in_data;
                    else if (accept)       skid_data <= in_data;
                end
                FULL: begin
                    if (deliver) main_data <= skid_data;
                end
                default: begin
                    main_data <= main_data;
                end
            endcase
        end
    end

endmodule
